// File: rtl/instr_encoder_if.sv
// Instruction-field stream and instruction-memory write bus for the program loader.
interface instr_encoder_if #(
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [3:0]        in_op;
  logic [1:0]        in_rs;
  logic [1:0]        in_rt;
  logic [1:0]        in_rd;
  logic [11:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              imem_ready;

  modport master (
    output in_valid, in_last, in_op, in_rs, in_rt, in_rd, in_imm, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_last, in_op, in_rs, in_rt, in_rd, in_imm, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Program loader: packs symbolic instruction fields into 16-bit R/I/J words and
// writes them sequentially into instruction memory from a programmable base.
module instr_encoder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instr_encoder_if.slave    bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written,
  output logic              imm_err,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t      state;
  logic        last;
  logic        is_itype;
  logic        imm_bad;
  logic [15:0] enc;

  always_comb begin
    enc      = '0;
    is_itype = (bus.in_op >= 4'hA) && (bus.in_op <= 4'hE);
    if (bus.in_op <= 4'h9)
      enc = {bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, 6'b0};
    else if (is_itype)
      enc = {bus.in_op, bus.in_rs, bus.in_rt, bus.in_imm[7:0]};
    else
      enc = {bus.in_op, bus.in_imm};
  end

  // Immediate fits in 8 signed bits only when the upper nibble is a sign extension.
  assign imm_bad = is_itype && (bus.in_imm[11:8] != {4{bus.in_imm[7]}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      last           <= 1'b0;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      words_written  <= '0;
      imm_err        <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bus.imem_addr <= base_addr;
            words_written <= '0;
            imm_err       <= 1'b0;
            overflow      <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            bus.imem_wdata <= enc;
            last           <= bus.in_last;
            if (imm_bad) imm_err <= 1'b1;
            bus.in_ready   <= 1'b0;
            bus.imem_we    <= 1'b1;
            state          <= WRITE;
          end
        end
        WRITE: begin
          if (bus.imem_ready) begin
            bus.imem_we   <= 1'b0;
            words_written <= words_written + 1'b1;
            if (last || bus.imem_addr == LAST_ADDR) begin
              // Addresses never wrap: a non-last word at the top ends the session.
              if (!last) overflow <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              bus.imem_addr <= bus.imem_addr + 1'b1;
              bus.in_ready  <= 1'b1;
              state         <= LOAD;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized sessions
// compared against an arithmetic model of the encoding and addressing rules.
module tb_instr_encoder;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, imm_err, overflow;
  logic [AW:0]   words_written;

  instr_encoder_if #(.ADDR_W(AW)) bus ();

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .bus(bus),
    .busy(busy), .done(done), .words_written(words_written), .imm_err(imm_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  rs, rt, rd;
    logic [11:0] imm;
    bit          last;
  } ins_t;

  ins_t prog[$];
  int   checks = 0, failures = 0;
  int   c_addr[$], c_data[$];
  int   done_cnt = 0;
  bit   mon_en = 1'b0;
  int   exp_addr[$], exp_data[$];
  int   exp_ww, n_accepted;
  bit   exp_ierr, exp_ovf;

  // A write is seen at the negedge before the edge that commits it.
  always @(negedge clk) begin
    if (mon_en && bus.imem_we && bus.imem_ready) begin
      c_addr.push_back(int'(bus.imem_addr));
      c_data.push_back(int'(bus.imem_wdata));
    end
    if (mon_en && done) done_cnt++;
  end

  function automatic int encode(ins_t i);
    int op = int'(i.op);
    if (op < 10)  return op * 4096 + int'(i.rs) * 1024 + int'(i.rt) * 256 + int'(i.rd) * 64;
    if (op == 15) return op * 4096 + int'(i.imm);
    return op * 4096 + int'(i.rs) * 1024 + int'(i.rt) * 256 + (int'(i.imm) % 256);
  endfunction

  function automatic bit imm_fits(ins_t i);
    int sv = (int'(i.imm) >= 2048) ? int'(i.imm) - 4096 : int'(i.imm);
    return (sv >= -128) && (sv <= 127);
  endfunction

  task automatic model_session(input int base);
    int addr = base;
    exp_addr.delete(); exp_data.delete();
    exp_ww = 0; exp_ierr = 0; exp_ovf = 0;
    foreach (prog[k]) begin
      exp_addr.push_back(addr);
      exp_data.push_back(encode(prog[k]));
      exp_ww++;
      if (prog[k].op >= 10 && prog[k].op <= 14 && !imm_fits(prog[k])) exp_ierr = 1;
      if (prog[k].last) break;
      if (addr == DEPTH - 1) begin exp_ovf = 1; break; end
      addr++;
    end
  endtask

  task automatic drive_ins(input ins_t i);
    bus.in_op = i.op; bus.in_rs = i.rs; bus.in_rt = i.rt; bus.in_rd = i.rd;
    bus.in_imm = i.imm; bus.in_last = i.last;
  endtask

  function automatic ins_t mk(int op, int rs, int rt, int rd, int imm, bit last);
    ins_t i;
    i.op = 4'(op); i.rs = 2'(rs); i.rt = 2'(rt); i.rd = 2'(rd); i.imm = 12'(imm); i.last = last;
    return i;
  endfunction

  // Drives one whole session from prog; inputs change 1 time unit after posedge.
  task automatic run_session(input int base, input int ready_pct, output bit timed_out);
    int idx = 0, cyc = 0;
    bit seen = 0, acc;
    c_addr.delete(); c_data.delete(); done_cnt = 0; mon_en = 1;
    @(posedge clk); #1; start = 1; base_addr = AW'(base);
    @(posedge clk); #1; start = 0;
    while (!seen && cyc < 300) begin
      bus.in_valid = (idx < prog.size());
      if (idx < prog.size()) drive_ins(prog[idx]);
      bus.imem_ready = ($urandom_range(0, 99) < ready_pct);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (done) seen = 1;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    repeat (3) begin
      bus.in_valid = (idx < prog.size());
      if (idx < prog.size()) drive_ins(prog[idx]);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    bus.in_valid = 0; bus.imem_ready = 0; mon_en = 0;
    n_accepted = idx;
    timed_out = !seen;
  endtask

  task automatic test_reset();
    reset_n = 0;
    #3;
    checks++;
    if ({bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, busy, done,
         words_written, imm_err, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_values got ready=%b we=%b addr=%0d wdata=%h busy=%b done=%b ww=%0d ierr=%b ovf=%b, want all 0",
               bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, busy, done, words_written, imm_err, overflow);
    end
    @(negedge clk); reset_n = 1;
  endtask

  task automatic test_single_add();
    bit to;
    prog.delete();
    prog.push_back(mk(3, 1, 2, 3, 0, 1));
    run_session(0, 100, to);
    checks++; if (to) begin failures++; $display("FAIL add_timeout got no done, want done"); end
    checks++;
    if (c_data.size() != 1 || c_addr[0] != 0 || c_data[0] != 'h36C0) begin
      failures++;
      $display("FAIL add_write got %0d writes first=%h@%0d, want 1 write 36c0@0",
               c_data.size(), c_data.size() ? c_data[0] : -1, c_addr.size() ? c_addr[0] : -1);
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL add_done got %0d pulses, want 1", done_cnt); end
    checks++; if (words_written !== 5'd1) begin failures++; $display("FAIL add_ww got %0d, want 1", words_written); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL add_busy got %b, want 0", busy); end
  endtask

  task automatic test_three_word();
    bit to;
    int ea[3] = '{5, 6, 7};
    int ed[3] = '{'hC1FD, 'hEB04, 'hF123};
    prog.delete();
    prog.push_back(mk(12, 0, 1, 0, 'hFFD, 0));
    prog.push_back(mk(14, 2, 3, 0, 'h004, 0));
    prog.push_back(mk(15, 0, 0, 0, 'h123, 1));
    run_session(5, 100, to);
    checks++; if (to) begin failures++; $display("FAIL three_timeout got no done, want done"); end
    checks++; if (c_data.size() != 3) begin failures++; $display("FAIL three_count got %0d, want 3", c_data.size()); end
    for (int k = 0; k < 3 && k < c_data.size(); k++) begin
      checks++;
      if (c_addr[k] != ea[k] || c_data[k] != ed[k]) begin
        failures++;
        $display("FAIL three_word%0d got %h@%0d, want %h@%0d", k, c_data[k], c_addr[k], ed[k], ea[k]);
      end
    end
    checks++; if (words_written !== 5'd3) begin failures++; $display("FAIL three_ww got %0d, want 3", words_written); end
    checks++; if (imm_err !== 1'b0) begin failures++; $display("FAIL three_immerr got %b, want 0", imm_err); end
  endtask

  task automatic test_imm_err();
    bit to;
    prog.delete();
    prog.push_back(mk(12, 1, 1, 0, 'h080, 1));
    run_session(2, 70, to);
    checks++;
    if (to || c_data.size() != 1 || c_data[0] != 'hC580 || c_addr[0] != 2) begin
      failures++;
      $display("FAIL immerr_write got %0d writes first=%h, want 1 write c580@2", c_data.size(), c_data.size() ? c_data[0] : -1);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (imm_err !== 1'b1) begin failures++; $display("FAIL immerr_sticky got %b, want 1", imm_err); end
  endtask

  task automatic test_stall();
    logic [AW-1:0] a0;
    logic [15:0]   d0;
    int            cyc = 0;
    c_addr.delete(); c_data.delete(); done_cnt = 0; mon_en = 1;
    @(posedge clk); #1; start = 1; base_addr = 4'd9; bus.imem_ready = 0;
    @(posedge clk); #1; start = 0; bus.in_valid = 1; drive_ins(mk(11, 2, 1, 0, 'h07F, 1));
    @(negedge clk);
    checks++; if (imm_err !== 1'b0) begin failures++; $display("FAIL stall_immerr_clear got %b, want 0", imm_err); end
    @(posedge clk); #1; bus.in_valid = 0;
    @(negedge clk);
    a0 = bus.imem_addr; d0 = bus.imem_wdata;
    checks++;
    if (bus.imem_we !== 1'b1 || a0 !== 4'd9 || d0 !== 16'hB97F) begin
      failures++;
      $display("FAIL stall_word got we=%b %h@%0d, want we=1 b97f@9", bus.imem_we, d0, a0);
    end
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (bus.imem_we !== 1'b1 || bus.imem_addr !== a0 || bus.imem_wdata !== d0 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold got we=%b %h@%0d ready=%b, want we=1 %h@%0d ready=0",
                 bus.imem_we, bus.imem_wdata, bus.imem_addr, bus.in_ready, d0, a0);
      end
    end
    @(posedge clk); #1; bus.imem_ready = 1;
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    @(posedge clk); #1; bus.imem_ready = 0;
    repeat (2) @(posedge clk);
    mon_en = 0;
    checks++;
    if (c_data.size() != 1 || done_cnt != 1) begin
      failures++;
      $display("FAIL stall_commit got %0d commits %0d done pulses, want 1 and 1", c_data.size(), done_cnt);
    end
  endtask

  task automatic test_overflow();
    bit to;
    prog.delete();
    prog.push_back(mk(2, 1, 0, 3, 0, 0));
    prog.push_back(mk(13, 3, 2, 0, 'h010, 0));
    prog.push_back(mk(15, 0, 0, 0, 'hABC, 0));
    model_session(14);
    run_session(14, 80, to);
    checks++; if (to) begin failures++; $display("FAIL ovf_timeout got no done, want done"); end
    checks++;
    if (c_addr.size() != 2 || c_addr[0] != 14 || c_addr[1] != 15 || c_data[0] != exp_data[0] || c_data[1] != exp_data[1]) begin
      failures++;
      $display("FAIL ovf_writes got %0d writes, want 2 at 14 and 15 (%h %h)", c_addr.size(), exp_data[0], exp_data[1]);
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got %b, want 1", overflow); end
    checks++; if (n_accepted != 2) begin failures++; $display("FAIL ovf_accepted got %0d, want 2", n_accepted); end
    checks++; if (words_written !== 5'd2) begin failures++; $display("FAIL ovf_ww got %0d, want 2", words_written); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL ovf_done got %0d pulses, want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_write();
    bit to;
    @(posedge clk); #1; start = 1; base_addr = 4'd3; bus.imem_ready = 0;
    @(posedge clk); #1; start = 0; bus.in_valid = 1; drive_ins(mk(1, 3, 3, 3, 0, 1));
    @(posedge clk); #1; bus.in_valid = 0;
    @(negedge clk);
    checks++; if (bus.imem_we !== 1'b1) begin failures++; $display("FAIL midrst_inwrite got we=%b, want 1", bus.imem_we); end
    @(posedge clk); #1; reset_n = 0;
    #1;
    checks++;
    if ({bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, busy, done,
         words_written, imm_err, overflow} !== '0) begin
      failures++;
      $display("FAIL midrst_values got ready=%b we=%b addr=%0d busy=%b ww=%0d, want all 0",
               bus.in_ready, bus.imem_we, bus.imem_addr, busy, words_written);
    end
    @(negedge clk); reset_n = 1;
    prog.delete();
    prog.push_back(mk(10, 1, 2, 0, 'hF80, 0));
    prog.push_back(mk(4, 0, 1, 2, 0, 1));
    model_session(7);
    run_session(7, 100, to);
    checks++;
    if (to || c_data.size() != 2 || c_addr[0] != 7 || c_data[0] != exp_data[0] || c_data[1] != exp_data[1]) begin
      failures++;
      $display("FAIL midrst_after got %0d writes, want 2 from addr 7", c_data.size());
    end
  endtask

  task automatic test_random();
    bit to;
    for (int s = 0; s < 24; s++) begin
      int base = $urandom_range(0, DEPTH - 1);
      int len  = $urandom_range(1, 6);
      prog.delete();
      for (int k = 0; k < len; k++) begin
        int imm = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 4095) : ($urandom_range(0, 255) + 3968) % 4096;
        prog.push_back(mk($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), imm, k == len - 1));
      end
      model_session(base);
      run_session(base, $urandom_range(30, 100), to);
      checks++;
      if (to || c_data.size() != exp_data.size()) begin
        failures++;
        $display("FAIL rand%0d_count got %0d writes timeout=%b, want %0d", s, c_data.size(), to, exp_data.size());
      end
      for (int k = 0; k < c_data.size() && k < exp_data.size(); k++) begin
        checks++;
        if (c_addr[k] != exp_addr[k] || c_data[k] != exp_data[k]) begin
          failures++;
          $display("FAIL rand%0d_word%0d got %h@%0d, want %h@%0d", s, k, c_data[k], c_addr[k], exp_data[k], exp_addr[k]);
        end
      end
      checks++;
      if (int'(words_written) != exp_ww || imm_err !== exp_ierr || overflow !== exp_ovf ||
          n_accepted != exp_ww || done_cnt != 1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d_status got ww=%0d ierr=%b ovf=%b acc=%0d done=%0d busy=%b, want ww=%0d ierr=%b ovf=%b acc=%0d done=1 busy=0",
                 s, words_written, imm_err, overflow, n_accepted, done_cnt, busy, exp_ww, exp_ierr, exp_ovf, exp_ww);
      end
    end
  endtask

  initial begin
    bus.in_valid = 0; bus.in_last = 0; bus.in_op = '0; bus.in_rs = '0; bus.in_rt = '0;
    bus.in_rd = '0; bus.in_imm = '0; bus.imem_ready = 0;
    test_reset();
    test_single_add();
    test_three_word();
    test_imm_err();
    test_stall();
    test_overflow();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
